// File: rtl/hex_frame_uart_tx_pkg.sv
// Shared constants, state encodings and helpers for the hex frame UART dump path.
// HEX_FRAME_LINE_CHECKSUM_EN adds the per-line checksum states.
package hex_frame_uart_tx_pkg;

  localparam logic [7:0] HASH = 8'h23;
  localparam logic [7:0] PLUS = 8'h2B;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HASH,
    ST_FETCH,
    ST_LATCH,
    ST_HEX,
`ifdef HEX_FRAME_LINE_CHECKSUM_EN
    ST_CSUM_HI,
    ST_CSUM_LO,
`endif
    ST_PLUS,
    ST_DONE
  } frame_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Uppercase only: the frame loader accepts nothing else.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble);
    return (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
  endfunction

  function automatic int clks_per_bit(input int clock_rate, input int baud_rate);
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/hex_frame_uart_tx_uart_tx_byte.sv
// 8N1 byte serialiser, LSB first; the transmit counterpart of uart_rx.
module uart_tx_byte
  import hex_frame_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 12
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic       i_VALID,
  input  logic [7:0] i_DATA,
  output logic       o_READY,
  output logic       o_TX
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  tx_state_t        state, state_d;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             baud_done;

  assign baud_done = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign o_READY   = (state == TX_IDLE);
  assign o_TX      = tx_q;

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  // The line level is derived from the next state so o_TX is a clean flop.
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt + 1'b1;
    bit_idx_d  = bit_idx;
    shift_d    = shift_q;
    tx_d       = 1'b1;
    case (state)
      TX_IDLE: begin
        baud_cnt_d = '0;
        if (i_VALID) begin
          state_d   = TX_START;
          shift_d   = i_DATA;
          bit_idx_d = '0;
        end
      end
      TX_START: begin
        if (baud_done) begin
          state_d    = TX_DATA;
          baud_cnt_d = '0;
        end
      end
      TX_DATA: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          bit_idx_d  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = TX_STOP;
          else                 shift_d = {1'b0, shift_q[7:1]};
        end
      end
      TX_STOP: begin
        if (baud_done) begin
          state_d    = TX_IDLE;
          baud_cnt_d = '0;
        end
      end
      default: state_d = TX_IDLE;
    endcase
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: rtl/hex_frame_uart_tx.sv
// Frame buffer dump as "#", hex lines and "+" separators over 8N1 UART.
// Define HEX_FRAME_LINE_CHECKSUM_EN to append a two-char nibble sum per line.
module hex_frame_uart_tx
  import hex_frame_uart_tx_pkg::*;
#(
  parameter int CLOCK_RATE  = 27_000_000,
  parameter int BAUD_RATE   = 2_200_000,
  parameter int LINE_PIXELS = 300,
  parameter int NUM_LINES   = 608,
  parameter int ADDR_W      = 10
) (
  input  logic                   i_CLK,
  input  logic                   i_RST_N,
  input  logic                   i_START,
  output logic                   o_BUSY,
  output logic                   o_DONE,
  output logic                   o_RD_EN,
  output logic [ADDR_W-1:0]      o_RD_ADDR,
  input  logic [LINE_PIXELS-1:0] i_RD_DATA,
  output logic                   o_TX
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_RATE, BAUD_RATE);
  localparam int HEX_CHARS    = LINE_PIXELS / 4;
  localparam int NIB_W        = (HEX_CHARS > 1) ? $clog2(HEX_CHARS) : 1;
  localparam logic [NIB_W-1:0]  LAST_NIB  = NIB_W'(HEX_CHARS - 1);
  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(NUM_LINES - 1);

  frame_state_t           state, state_d;
  logic [ADDR_W-1:0]      line_idx;
  logic [NIB_W-1:0]       nib_idx;
  logic [LINE_PIXELS-1:0] line_q;
  logic                   tx_valid, tx_ready;
  logic [7:0]             tx_data;
  logic                   done_pulse;
  logic                   last_line;
`ifdef HEX_FRAME_LINE_CHECKSUM_EN
  logic [7:0]             csum_q;
`endif

  assign last_line = (line_idx == LAST_LINE);
  assign o_RD_EN   = (state == ST_FETCH);
  assign o_RD_ADDR = line_idx;
  assign o_DONE    = done_pulse;
  assign o_BUSY    = (state != ST_IDLE) && !done_pulse;

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state    <= ST_IDLE;
      line_idx <= '0;
      nib_idx  <= '0;
      line_q   <= '0;
`ifdef HEX_FRAME_LINE_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state <= state_d;
      case (state)
        ST_IDLE:  if (i_START) line_idx <= '0;
        ST_LATCH: begin
          line_q  <= i_RD_DATA;
          nib_idx <= '0;
`ifdef HEX_FRAME_LINE_CHECKSUM_EN
          csum_q  <= '0;
`endif
        end
        // The current nibble always sits in line_q[3:0].
        ST_HEX: if (tx_ready) begin
          line_q  <= line_q >> 4;
          nib_idx <= nib_idx + 1'b1;
`ifdef HEX_FRAME_LINE_CHECKSUM_EN
          csum_q  <= csum_q + {4'h0, line_q[3:0]};
`endif
        end
        ST_PLUS:  if (tx_ready) line_idx <= line_idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state;
    tx_valid   = 1'b0;
    tx_data    = HASH;
    done_pulse = 1'b0;
    case (state)
      ST_IDLE:  if (i_START) state_d = ST_HASH;
      ST_HASH: begin
        tx_valid = 1'b1;
        tx_data  = HASH;
        if (tx_ready) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: state_d = ST_HEX;
      ST_HEX: begin
        tx_valid = 1'b1;
        tx_data  = nibble_to_ascii(line_q[3:0]);
        if (tx_ready && (nib_idx == LAST_NIB)) begin
`ifdef HEX_FRAME_LINE_CHECKSUM_EN
          state_d = ST_CSUM_HI;
`else
          state_d = last_line ? ST_DONE : ST_PLUS;
`endif
        end
      end
`ifdef HEX_FRAME_LINE_CHECKSUM_EN
      ST_CSUM_HI: begin
        tx_valid = 1'b1;
        tx_data  = nibble_to_ascii(csum_q[7:4]);
        if (tx_ready) state_d = ST_CSUM_LO;
      end
      ST_CSUM_LO: begin
        tx_valid = 1'b1;
        tx_data  = nibble_to_ascii(csum_q[3:0]);
        if (tx_ready) state_d = last_line ? ST_DONE : ST_PLUS;
      end
`endif
      ST_PLUS: begin
        tx_valid = 1'b1;
        tx_data  = PLUS;
        if (tx_ready) state_d = ST_FETCH;
      end
      // Ready again means the last stop bit has fully left the line.
      ST_DONE: begin
        if (tx_ready) begin
          done_pulse = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .i_CLK  (i_CLK),
    .i_RST_N(i_RST_N),
    .i_VALID(tx_valid),
    .i_DATA (tx_data),
    .o_READY(tx_ready),
    .o_TX   (o_TX)
  );

endmodule

// File: tb/tb_hex_frame_uart_tx.sv
// Scoreboard bench for hex_frame_uart_tx: a UART decoder monitor checks bytes,
// bit timing, read handshake and busy/done against a queue filled at each start.
module tb_hex_frame_uart_tx;

  localparam int CLOCK_RATE  = 4;
  localparam int BAUD_RATE   = 1;
  localparam int CPB         = 4;
  localparam int LINE_PIXELS = 8;
  localparam int NUM_LINES   = 3;
  localparam int ADDR_W      = 2;
  localparam int HEX_CHARS   = LINE_PIXELS / 4;
`ifdef HEX_FRAME_LINE_CHECKSUM_EN
  localparam int CSUM_CHARS  = 2;
`else
  localparam int CSUM_CHARS  = 0;
`endif
  localparam int FRAME_BYTES = 1 + NUM_LINES * (HEX_CHARS + CSUM_CHARS) + (NUM_LINES - 1);
  localparam int FRAME_BUDGET = FRAME_BYTES * 10 * CPB * 2 + 200;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic                   busy, done, rd_en, tx;
  logic [ADDR_W-1:0]      rd_addr;
  logic [LINE_PIXELS-1:0] rd_data = '0;
  logic [7:0]             bram [NUM_LINES];

  int         check_count = 0;
  int         error_count = 0;
  logic [7:0] exp_q [$];
  int         frames_pending = 0;
  int         next_rd_addr = 0;
  int         done_count = 0;
  string      hex_digits = "0123456789ABCDEF";

  hex_frame_uart_tx #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE),
    .LINE_PIXELS(LINE_PIXELS),
    .NUM_LINES  (NUM_LINES),
    .ADDR_W     (ADDR_W)
  ) dut (
    .i_CLK    (clk),
    .i_RST_N  (rst_n),
    .i_START  (start),
    .o_BUSY   (busy),
    .o_DONE   (done),
    .o_RD_EN  (rd_en),
    .o_RD_ADDR(rd_addr),
    .i_RD_DATA(rd_data),
    .o_TX     (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en && (int'(rd_addr) < NUM_LINES)) rd_data <= bram[rd_addr];
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: the frame text derived directly from the line contents.
  task automatic applyStimulus();
    int sum;
    int nib;
    exp_q.push_back("#");
    for (int l = 0; l < NUM_LINES; l++) begin
      sum = 0;
      for (int k = 0; k < HEX_CHARS; k++) begin
        nib = (int'(bram[l]) >> (4 * k)) % 16;
        sum += nib;
        exp_q.push_back(hex_digits[nib]);
      end
`ifdef HEX_FRAME_LINE_CHECKSUM_EN
      sum = sum % 256;
      exp_q.push_back(hex_digits[sum / 16]);
      exp_q.push_back(hex_digits[sum % 16]);
`endif
      if (l < NUM_LINES - 1) exp_q.push_back("+");
    end
    frames_pending++;
    next_rd_addr = 0;
    pulseStart();
  endtask

  task automatic pulseStart();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic resetPulse();
    @(posedge clk); #1 rst_n = 1'b0;
    exp_q.delete();
    frames_pending = 0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic waitDone();
    int n = 0;
    while (frames_pending > 0 && n < FRAME_BUDGET) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frame_complete_in_time", frames_pending == 0, 1'b1);
    if (frames_pending != 0) resetPulse();
    repeat (3) @(posedge clk);
  endtask

  task automatic waitLine(input int line);
    int n = 0;
    while (!(rd_en && int'(rd_addr) == line) && n < FRAME_BUDGET) begin
      @(negedge clk);
      n++;
    end
    checkOutput("line_fetch_seen", n < FRAME_BUDGET, 1'b1);
  endtask

  // Monitor: decodes o_TX over whole bit periods and tracks the read strobe.
  logic       samples [40];
  logic       capturing = 1'b0;
  int         cap_cnt = 0;
  int         gap = 0;
  logic       have_prev = 1'b0;
  logic       prev_rd_en = 1'b0;
  logic       prev_busy = 1'b0;
  logic       after_done = 1'b0;
  int         busy_cycles = 0;
  logic       timing_ok;
  logic [7:0] rx_byte;

  always @(negedge clk) begin
    if (!rst_n) begin
      capturing   = 1'b0;
      have_prev   = 1'b0;
      prev_rd_en  = 1'b0;
      prev_busy   = 1'b0;
      after_done  = 1'b0;
      busy_cycles = 0;
    end else begin
      if (rd_en) begin
        checkOutput("rd_en_single_cycle", prev_rd_en, 1'b0);
        checkOutput("rd_addr", rd_addr, next_rd_addr);
        next_rd_addr++;
      end
      prev_rd_en = rd_en;

      if (after_done) checkOutput("busy_after_done", busy, 1'b0);
      after_done = 1'b0;
      if (busy) busy_cycles++;
      if (done) begin
        done_count++;
        checkOutput("done_expected", frames_pending > 0, 1'b1);
        checkOutput("busy_before_done", prev_busy, 1'b1);
        checkOutput("bytes_left_at_done", exp_q.size(), 0);
        checkOutput("lines_read", next_rd_addr, NUM_LINES);
        checkOutput("busy_min", busy_cycles >= FRAME_BYTES * 10 * CPB, 1'b1);
        checkOutput("busy_max", busy_cycles <= FRAME_BYTES * (10 * CPB + 3) + 10, 1'b1);
        if (frames_pending > 0) frames_pending--;
        busy_cycles = 0;
        have_prev   = 1'b0;
        after_done  = 1'b1;
      end
      prev_busy = busy;

      if (capturing) begin
        samples[cap_cnt] = tx;
        cap_cnt++;
        if (cap_cnt == 10 * CPB) begin
          timing_ok = 1'b1;
          for (int i = 0; i < 10; i++)
            for (int j = 1; j < CPB; j++)
              if (samples[CPB * i + j] !== samples[CPB * i]) timing_ok = 1'b0;
          for (int b = 0; b < 8; b++) rx_byte[b] = samples[CPB * (b + 1)];
          checkOutput("bit_timing", timing_ok, 1'b1);
          checkOutput("stop_bit", samples[9 * CPB], 1'b1);
          checkOutput("byte_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) checkOutput("tx_byte", rx_byte, exp_q.pop_front());
          capturing = 1'b0;
          gap       = 0;
          have_prev = 1'b1;
        end
      end else if (tx == 1'b0) begin
        if (have_prev) checkOutput("inter_byte_gap", gap <= 3, 1'b1);
        samples[0] = tx;
        cap_cnt    = 1;
        capturing  = 1'b1;
      end else begin
        gap++;
      end
    end
  end

  initial begin
    int dc;
    int n;
    int line;
    bram[0] = 8'hA5;
    bram[1] = 8'h3C;
    bram[2] = 8'hF0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_rd_en", rd_en, 1'b0);
    checkOutput("reset_rd_addr", rd_addr, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    $display("[TB] single frame");
    applyStimulus();
    waitDone();

    $display("[TB] line held after latch");
    applyStimulus();
    waitLine(0);
    @(posedge clk); @(posedge clk); #1 bram[0] = 8'h00;
    waitDone();
    bram[0] = 8'hA5;

    $display("[TB] start while busy");
    applyStimulus();
    repeat (100) @(posedge clk);
    pulseStart();
    waitDone();

    $display("[TB] start in done cycle");
    applyStimulus();
    n = 0;
    dc = done_count;
    forever begin
      @(posedge clk); #1;
      if (done || n >= FRAME_BUDGET) break;
      n++;
    end
    checkOutput("done_seen_for_late_start", n < FRAME_BUDGET, 1'b1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (60) @(posedge clk);
    #1 checkOutput("busy_after_late_start", busy, 1'b0);
    checkOutput("single_done_late_start", done_count, dc + 1);
    waitDone();

    $display("[TB] reset mid byte");
    applyStimulus();
    waitLine(1);
    repeat (10) @(posedge clk);
    dc = done_count;
    resetPulse();
    @(negedge clk);
    checkOutput("mid_reset_tx", tx, 1'b1);
    checkOutput("mid_reset_busy", busy, 1'b0);
    checkOutput("mid_reset_rd_addr", rd_addr, 0);
    repeat (80) @(posedge clk);
    #1 checkOutput("no_done_after_reset", done_count, dc);
    applyStimulus();
    waitDone();

    $display("[TB] random frames");
    for (int f = 0; f < 8; f++) begin
      for (int l = 0; l < NUM_LINES; l++) bram[l] = 8'($urandom_range(0, 255));
      applyStimulus();
      line = $urandom_range(0, NUM_LINES - 1);
      waitLine(line);
      @(posedge clk); @(posedge clk); #1 bram[line] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 150)) @(posedge clk);
        if (busy) pulseStart();
      end
      waitDone();
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/hex_frame_uart_tx.md
Name: hex_frame_uart_tx

Overview:
- Dumps the frame buffer back out over UART. It uses the ASCII line protocol that the frame-loading UART path parses: "#" means reset to line 0, hex digits carry the pixel data, and "+" means next line.
- It reads one line per fetch from the frame-buffer read port, encodes the line as uppercase hex nibbles and serialises it 8N1.
- It sits in the 27 MHz domain beside the UART receiver. Its uses are host read-back, loopback test and board-to-board frame copy.

Parameters:
- CLOCK_RATE, 27_000_000, input clock frequency in Hz.
- BAUD_RATE, 2_200_000, UART bit rate. CLKS_PER_BIT = CLOCK_RATE/BAUD_RATE, truncated; must be >= 2.
- LINE_PIXELS, 300, bits per line. Must be a multiple of 4. HEX_CHARS = LINE_PIXELS/4.
- NUM_LINES, 608, number of lines sent per frame.
- ADDR_W, 10, read-address width. Must satisfy 2**ADDR_W >= NUM_LINES.

Ports:
- i_CLK  in  1  system clock.
- i_RST_N  in  1  reset: one clock, synchronous, active-low.
- i_START  in  1  one-cycle pulse that starts a frame dump. Ignored while o_BUSY=1.
- o_BUSY  out  1  high from the cycle after an accepted i_START until the end of the final stop bit.
- o_DONE  out  1  one-cycle pulse, asserted in the cycle o_BUSY falls.
- o_RD_EN  out  1  read strobe to the frame buffer.
- o_RD_ADDR  out  ADDR_W  line index.
- i_RD_DATA  in  LINE_PIXELS  line data, valid exactly 1 cycle after o_RD_EN (synchronous BRAM).
- o_TX  out  1  UART line, idle high.

Behaviour:
- Reset values: o_TX=1, o_BUSY=0, o_DONE=0, o_RD_EN=0, o_RD_ADDR=0. Reset applied mid-byte forces o_TX=1 on the next edge, abandons the frame, and emits no o_DONE.
- UART framing: 8N1, LSB first. Each bit lasts exactly CLKS_PER_BIT clocks. Idle gap between consecutive bytes is at most 3 clocks.
- Output stream for one frame:
  - "#" (0x23) first.
  - Then for each line L = 0..NUM_LINES-1: HEX_CHARS characters.
  - "+" (0x2B) between lines. No "+" after the last line.
  - Total bytes = 1 + NUM_LINES*HEX_CHARS + (NUM_LINES-1).
- Nibble order: char k (k = 0..HEX_CHARS-1) encodes i_RD_DATA[4k+3:4k]. Encoding is 0-9 to 0x30-0x39 and A-F to 0x41-0x46, uppercase only.
- Frame FSM states:
  - IDLE: on i_START go to HASH.
  - HASH: send "#", then FETCH.
  - FETCH: o_RD_EN=1 for one cycle with o_RD_ADDR=L, then LATCH.
  - LATCH: capture i_RD_DATA into the line shift register, nibble index = 0, then HEX.
  - HEX: send the current nibble. When index = HEX_CHARS-1, go to PLUS if L < NUM_LINES-1, else DONE.
  - PLUS: send "+", L = L+1, then FETCH.
  - DONE: pulse o_DONE, clear o_BUSY, return to IDLE.
- The line register is captured once per line. Frame-buffer writes during the line's transmission do not affect that line.
- i_START arriving in the same cycle as the o_DONE pulse is ignored. A new start is accepted from IDLE only.
- Counters are sized $clog2(HEX_CHARS) and ADDR_W. L never exceeds NUM_LINES-1, so no wrap-around occurs.

Optional Feature:
- Macro: HEX_FRAME_LINE_CHECKSUM_EN.
- Defined: after each line's HEX_CHARS characters and before "+" (or before DONE on the last line), two extra hex chars are sent. They are the 8-bit modulo-256 sum of that line's nibble values, high nibble first. Total bytes grow by 2*NUM_LINES. The receiver ignores these because they fall beyond LINE_PIXELS.
- Undefined: no checksum chars are sent, and the checksum logic is absent.

Decomposition:
- Shared package/include holds:
  - ASCII constants HASH=0x23, PLUS=0x2B.
  - The nibble-to-ASCII function.
  - FSM state encodings.
  - A CLKS_PER_BIT helper.
- Natural sub-module: uart_tx_byte.
  - Inputs i_CLK, i_RST_N, i_VALID, i_DATA[7:0]; outputs o_READY, o_TX.
  - Accepts a byte when valid & ready and owns the baud counter.
  - Pairs with the existing uart_rx.

Test Plan:
- Setup for all cases: CLOCK_RATE=4, BAUD_RATE=1 (4 clk/bit), LINE_PIXELS=8, NUM_LINES=3. BRAM model: line0=0xA5, line1=0x3C, line2=0xF0.
- Single start: pulse i_START → decoded bytes "#","5","A","+","C","3","+","0","F" (9 bytes). o_DONE pulses once. o_BUSY spans at most 9*40+27+overhead cycles.
- Bit timing: first byte 0x23 → o_TX low for 4 clk, then bits 1,1,0,0,0,1,0,0 at 4 clk each, then stop high for 4 clk.
- Read handshake: o_RD_ADDR sequence 0,1,2, each with a one-cycle o_RD_EN. Changing BRAM line0 to 0x00 after LATCH does not alter the "5","A" output.
- Start while busy: second i_START mid-frame → ignored, still exactly 9 bytes and one o_DONE.
- Reset mid-byte: deassert i_RST_N during line1 → o_TX=1 next cycle, o_BUSY=0, no o_DONE. A fresh i_START then yields the full 9-byte stream.
- With HEX_FRAME_LINE_CHECKSUM_EN: line0 chars "5","A","0","F" (5+10=0x0F), 15 bytes total.
